// File: rtl/dp_types_pkg.sv
// Shared types for the BTB controller: predictor counter encoding,
// in-flight queue entry layout and the controller FSM states.
package dp_types_pkg;

  typedef enum logic [1:0] {
    BPRED_NH = 2'd0,
    BPRED_NS = 2'd1,
    BPRED_TS = 2'd2,
    BPRED_TH = 2'd3
  } bpred_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_ctrl_state_t;

  typedef struct packed {
    logic [31:0]  pc;
    bpred_state_t state;
    logic         pred_taken;
    logic [31:0]  pred_target;
  } btb_pred_entry_t;

  localparam int          ENTRY_W = $bits(btb_pred_entry_t);
  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic predicts_taken(input bpred_state_t s);
    return (s == BPRED_TS) || (s == BPRED_TH);
  endfunction

endpackage

// File: rtl/btb_controller_pred_queue.sv
// In-order FIFO of in-flight branch predictions with a single-cycle clear
// used to squash everything younger than a mispredicted branch.
module pred_queue
  import dp_types_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  output logic [ENTRY_W-1:0] head,
  output logic               empty,
  output logic               full
);
  localparam int PTR_W = $clog2(QDEPTH);

  logic [ENTRY_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(QDEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_controller.sv
// BTB sequencer: combinational fetch prediction, in-order resolve with BTB
// update and squash, and an invalidate sweep that owns the BTB write port.
module btb_controller
  import dp_types_pkg::*;
#(
  parameter int IND_W  = 8,
  parameter int QDEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             f_req,
  input  logic             f_is_branch,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  output logic [31:0]      f_pred_target,
  output logic             q_full,
  output logic [IND_W-1:0] btb_rsel,
  input  logic [1:0]       btb_rdat_state,
  input  logic [31:0]      btb_rdat_target,
  input  logic             r_valid,
  input  logic             r_taken,
  input  logic [31:0]      r_target,
  output logic             r_mispredict,
  output logic [31:0]      r_correct_pc,
  output logic             r_err,
  output logic             btb_wen,
  output logic [IND_W-1:0] btb_wsel,
  output logic [1:0]       btb_wdat_state,
  output logic [31:0]      btb_wdat_target,
  output logic             btb_phit,
  input  logic             inv_req,
  output logic             inv_busy
);
  localparam logic [IND_W-1:0] LAST_IDX = {IND_W{1'b1}};

  btb_ctrl_state_t    state;
  btb_ctrl_state_t    state_nxt;
  logic [IND_W-1:0]   sweep_idx;
  logic [IND_W-1:0]   sweep_idx_nxt;
  btb_pred_entry_t    push_entry;
  btb_pred_entry_t    head;
  logic [ENTRY_W-1:0] head_bits;
  logic               q_empty;
  logic               resolve;
  logic               push;
  logic               sweeping;
  bpred_state_t       rd_state;
  bpred_state_t       wr_state;

  assign sweeping = (state == SWEEP);
  assign inv_busy = sweeping;

  // Fetch-side prediction straight off the BTB read port.
  assign rd_state      = bpred_state_t'(btb_rdat_state);
  assign btb_rsel      = f_pc[IND_W+1:2];
  assign f_pred_taken  = !sweeping && predicts_taken(rd_state);
  assign f_pred_target = btb_rdat_target;

  assign push_entry = '{pc:          f_pc,
                        state:       rd_state,
                        pred_taken:  f_pred_taken,
                        pred_target: btb_rdat_target};
  assign head       = btb_pred_entry_t'(head_bits);

  // Resolve always checks the oldest entry; a mispredict also kills any
  // branch fetched down the wrong path in this same cycle.
  assign resolve      = r_valid && !q_empty;
  assign r_err        = r_valid && q_empty;
  assign r_mispredict = resolve &&
                        ((head.pred_taken != r_taken) ||
                         (r_taken && (head.pred_target != r_target)));
  assign r_correct_pc = r_taken ? r_target : (head.pc + PC_STEP);
  assign push         = f_req && f_is_branch && !q_full && !r_mispredict;

  pred_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk      (CLK),
    .rst_n    (nRST),
    .push     (push),
    .push_data(push_entry),
    .pop      (resolve),
    .clear    (r_mispredict),
    .head     (head_bits),
    .empty    (q_empty),
    .full     (q_full)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      IDLE: begin
        sweep_idx_nxt = '0;
        if (inv_req) state_nxt = SWEEP;
      end
      SWEEP: begin
        sweep_idx_nxt = sweep_idx + IND_W'(1);
        if (sweep_idx == LAST_IDX) state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        sweep_idx_nxt = '0;
      end
    endcase
  end

  // The sweep owns the write port; a resolve during the sweep loses its update.
  always_comb begin
    btb_wen         = 1'b0;
    btb_wsel        = '0;
    wr_state        = BPRED_NH;
    btb_wdat_target = '0;
    btb_phit        = 1'b0;
    if (sweeping) begin
      btb_wen  = 1'b1;
      btb_wsel = sweep_idx;
      wr_state = BPRED_NH;
      btb_phit = 1'b1;
    end else if (resolve) begin
      btb_wen         = 1'b1;
      btb_wsel        = head.pc[IND_W+1:2];
      wr_state        = head.state;
      btb_wdat_target = r_taken ? r_target : head.pred_target;
      btb_phit        = r_taken;
    end
  end

  assign btb_wdat_state = wr_state;

endmodule

// File: tb/tb_btb_controller.sv
// Randomized scoreboard bench for btb_controller with a behavioural BTB and
// a queue-based reference model of the in-flight branch bookkeeping.
module tb_btb_controller;
  import dp_types_pkg::*;

  localparam int IND_W  = 8;
  localparam int QDEPTH = 4;
  localparam int NENT   = 256;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             f_req, f_is_branch;
  logic [31:0]      f_pc;
  logic             f_pred_taken;
  logic [31:0]      f_pred_target;
  logic             q_full;
  logic [IND_W-1:0] btb_rsel;
  logic [1:0]       btb_rdat_state;
  logic [31:0]      btb_rdat_target;
  logic             r_valid, r_taken;
  logic [31:0]      r_target;
  logic             r_mispredict;
  logic [31:0]      r_correct_pc;
  logic             r_err;
  logic             btb_wen;
  logic [IND_W-1:0] btb_wsel;
  logic [1:0]       btb_wdat_state;
  logic [31:0]      btb_wdat_target;
  logic             btb_phit;
  logic             inv_req;
  logic             inv_busy;

  always #5 CLK = ~CLK;

  btb_controller #(.IND_W(IND_W), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .f_req(f_req), .f_is_branch(f_is_branch), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target), .q_full(q_full),
    .btb_rsel(btb_rsel), .btb_rdat_state(btb_rdat_state), .btb_rdat_target(btb_rdat_target),
    .r_valid(r_valid), .r_taken(r_taken), .r_target(r_target),
    .r_mispredict(r_mispredict), .r_correct_pc(r_correct_pc), .r_err(r_err),
    .btb_wen(btb_wen), .btb_wsel(btb_wsel), .btb_wdat_state(btb_wdat_state),
    .btb_wdat_target(btb_wdat_target), .btb_phit(btb_phit),
    .inv_req(inv_req), .inv_busy(inv_busy)
  );

  // Saturating 2-bit counter applied by the BTB on every write.
  function automatic logic [1:0] ctr_step(input logic [1:0] s, input logic up);
    if (up) return (s == 2'd3) ? s : s + 2'd1;
    return (s == 2'd0) ? s : s - 2'd1;
  endfunction

  // Behavioural BTB: write captured on the falling edge, visible next cycle.
  logic [1:0]  mem_st [NENT];
  logic [31:0] mem_tg [NENT];
  logic        btb_clear;
  logic        pend;
  logic [7:0]  pidx;
  logic [1:0]  pst;
  logic [31:0] ptg;

  assign btb_rdat_state  = mem_st[btb_rsel];
  assign btb_rdat_target = mem_tg[btb_rsel];

  always @(negedge CLK) begin
    pend <= btb_wen;
    pidx <= btb_wsel;
    pst  <= ctr_step(btb_wdat_state, btb_phit);
    ptg  <= btb_wdat_target;
  end

  always @(posedge CLK) begin
    if (btb_clear) begin
      for (int i = 0; i < NENT; i++) begin
        mem_st[i] <= 2'd1;
        mem_tg[i] <= 32'd0;
      end
    end else if (pend === 1'b1) begin
      mem_st[pidx] <= pst;
      mem_tg[pidx] <= ptg;
    end
  end

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  st;
    logic        pt;
    logic [31:0] ptg;
  } ent_t;

  typedef struct {
    bit          chk_pred;
    logic        pt;
    logic [31:0] ptg;
    logic        misp;
    logic        err;
    bit          chk_pc;
    logic [31:0] cpc;
    logic        full;
    logic        busy;
    logic        wen;
    logic [7:0]  wsel;
    logic [1:0]  wst;
    logic [31:0] wtg;
    logic        phit;
  } exp_t;

  ent_t        mq[$];
  exp_t        expq[$];
  logic [1:0]  ref_st [NENT];
  logic [31:0] ref_tg [NENT];
  bit          m_sweep;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;
  exp_t        me;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic step(input logic fq, input logic fb, input logic [31:0] pc,
                      input logic rv, input logic rt, input logic [31:0] rtg,
                      input logic inv);
    exp_t e;
    ent_t h;
    ent_t n;
    int   idx;
    bit   full;
    bit   misp;
    f_req = fq; f_is_branch = fb; f_pc = pc;
    r_valid = rv; r_taken = rt; r_target = rtg; inv_req = inv;
    e = '{default: '0};
    full   = (mq.size() == QDEPTH);
    idx    = int'(pc[9:2]);
    e.full = full;
    e.busy = m_sweep;
    n.pc  = pc;
    n.st  = ref_st[idx];
    n.pt  = !m_sweep && (ref_st[idx] >= 2'd2);
    n.ptg = ref_tg[idx];
    if (fq && fb) begin
      e.chk_pred = 1'b1;
      e.pt  = n.pt;
      e.ptg = n.ptg;
    end
    misp = 1'b0;
    if (rv) begin
      if (mq.size() == 0) begin
        e.err = 1'b1;
      end else begin
        h = mq.pop_front();
        misp     = (h.pt != rt) || (rt && (h.ptg != rtg));
        e.misp   = misp;
        e.chk_pc = 1'b1;
        e.cpc    = rt ? rtg : h.pc + 32'd4;
        if (!m_sweep) begin
          e.wen = 1'b1; e.wsel = h.pc[9:2]; e.wst = h.st;
          e.wtg = rt ? rtg : h.ptg; e.phit = rt;
        end
      end
    end
    if (m_sweep) begin
      e.wen = 1'b1; e.wsel = 8'(m_cnt); e.wst = 2'd0; e.wtg = 32'd0; e.phit = 1'b1;
    end
    if (misp) mq.delete();
    else if (fq && fb && !full) mq.push_back(n);
    if (e.wen) begin
      ref_st[e.wsel] = ctr_step(e.wst, e.phit);
      ref_tg[e.wsel] = e.wtg;
    end
    if (m_sweep) begin
      m_cnt++;
      if (m_cnt == NENT) m_sweep = 1'b0;
    end else if (inv) begin
      m_sweep = 1'b1;
      m_cnt   = 0;
    end
    expq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b1, 1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic res(input logic rt, input logic [31:0] rtg);
    step(1'b0, 1'b0, 32'd0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    f_req = 1'b0; f_is_branch = 1'b0; f_pc = 32'd0;
    r_valid = 1'b0; r_taken = 1'b0; r_target = 32'd0; inv_req = 1'b0;
    mq.delete();
    m_sweep = 1'b0;
    m_cnt   = 0;
    #1;
    chk("rst_q_full", 32'(q_full), 32'd0);
    chk("rst_inv_busy", 32'(inv_busy), 32'd0);
    chk("rst_btb_wen", 32'(btb_wen), 32'd0);
    chk("rst_r_mispredict", 32'(r_mispredict), 32'd0);
    chk("rst_r_err", 32'(r_err), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        me = expq.pop_front();
        chk("q_full", 32'(q_full), 32'(me.full));
        chk("inv_busy", 32'(inv_busy), 32'(me.busy));
        chk("btb_wen", 32'(btb_wen), 32'(me.wen));
        chk("r_mispredict", 32'(r_mispredict), 32'(me.misp));
        chk("r_err", 32'(r_err), 32'(me.err));
        if (me.wen) begin
          chk("btb_wsel", 32'(btb_wsel), 32'(me.wsel));
          chk("btb_wdat_state", 32'(btb_wdat_state), 32'(me.wst));
          chk("btb_wdat_target", btb_wdat_target, me.wtg);
          chk("btb_phit", 32'(btb_phit), 32'(me.phit));
        end
        if (me.chk_pred) begin
          chk("f_pred_taken", 32'(f_pred_taken), 32'(me.pt));
          chk("f_pred_target", f_pred_target, me.ptg);
        end
        if (me.chk_pc) chk("r_correct_pc", r_correct_pc, me.cpc);
      end
    end
  end

  logic        s_fq, s_fb, s_rv, s_rt, s_inv;
  logic [31:0] s_pc, s_rtg;
  int          nbusy;
  int          nbad;

  initial begin
    for (int i = 0; i < NENT; i++) begin
      ref_st[i] = 2'd1;
      ref_tg[i] = 32'd0;
    end
    btb_clear = 1'b1;
    do_reset();
    btb_clear = 1'b0;

    // Cold then warm prediction of the branch at 0x40 (index 0x10).
    fetch(32'h40);
    res(1'b1, 32'h100);
    fetch(32'h40);
    res(1'b1, 32'h100);
    chk("warm_saturates_th", 32'(mem_st[16]), 32'd3);

    // Fill the queue, attempt a blocked push alongside a pop, then drain.
    for (int i = 0; i < 4; i++) fetch(32'hA0 + 32'(i) * 4);
    chk("queue_full", 32'(q_full), 32'd1);
    step(1'b1, 1'b1, 32'hB0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) res(1'b0, 32'd0);

    // Squash: oldest of three mispredicts with a concurrent push.
    for (int i = 0; i < 3; i++) fetch(32'h80 + 32'(i) * 4);
    step(1'b1, 1'b1, 32'h8C, 1'b1, 1'b1, 32'h300, 1'b0);
    res(1'b1, 32'h300);

    // Sweep with a fetch and resolves issued while it runs.
    fetch(32'h40);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    nbusy = 0;
    while (inv_busy && nbusy < 400) begin
      nbusy++;
      if (nbusy == 5) step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 1'b1);
      else if (nbusy == 50 || nbusy == 60) res(1'b1, 32'h100);
      else idle();
    end
    chk("sweep_length", 32'(nbusy), 32'd256);
    nbad = 0;
    for (int i = 0; i < NENT; i++)
      if (mem_st[i] !== 2'd1 || mem_tg[i] !== 32'd0) nbad++;
    chk("sweep_cleared_entries", 32'(nbad), 32'd0);

    // Reset in the middle of a sweep, then restart from index 0.
    fetch(32'h44);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (100) idle();
    chk("sweep_at_idx100", 32'(btb_wsel), 32'd100);
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("restart_idx0", 32'(btb_wsel), 32'd0);
    for (int i = 0; i < 300 && inv_busy; i++) idle();

    // Randomized traffic with aliasing PCs and occasional sweeps.
    for (int c = 0; c < 1500; c++) begin
      s_fq  = ($urandom_range(0, 3) != 0);
      s_fb  = ($urandom_range(0, 1) != 0);
      s_pc  = (($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'h0)
              + 32'h40 + 32'($urandom_range(0, 15)) * 4;
      s_rv  = ($urandom_range(0, 2) == 0);
      s_inv = ($urandom_range(0, 299) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        s_rtg = mq[0].ptg;
        s_rt  = ($urandom_range(0, 4) == 0) ? !mq[0].pt : mq[0].pt;
      end else begin
        s_rtg = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
        s_rt  = ($urandom_range(0, 1) != 0);
      end
      step(s_fq, s_fb, s_pc, s_rv, s_rt, s_rtg, s_inv);
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_controller.md
# btb_controller

Sequencer and owner of the branch target buffer's read and write ports.
- Fetch side: issues a same-cycle prediction from the BTB read port and records it in a small in-order queue of in-flight branches.
- Execute side: pops the oldest entry when a branch resolves, flags a mispredict, supplies the corrected PC and writes the saturating-counter update.
- Invalidate sweep: walks all BTB entries, taking exclusive ownership of the write port while it runs.

## Interface
Parameters:
- IND_W, 8: BTB index width; 2**IND_W entries, index = pc[IND_W+1:2]
- QDEPTH, 4: in-flight prediction queue depth (power of two)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; one clock, reset asynchronous and active-low
- f_req  in  1  fetch issuing an instruction this cycle
- f_is_branch  in  1  issued instruction is a branch/jump needing prediction
- f_pc  in  32  fetch PC
- f_pred_taken  out  1  predict taken
- f_pred_target  out  32  predicted target
- q_full  out  1  queue holds QDEPTH entries; fetch must not issue a branch
- btb_rsel  out  IND_W  BTB read index
- btb_rdat_state  in  2  BTB read state (bpred_state_t)
- btb_rdat_target  in  32  BTB read target
- r_valid  in  1  oldest in-flight branch resolves this cycle
- r_taken  in  1  actual direction
- r_target  in  32  actual target
- r_mispredict  out  1  prediction wrong; fetch must redirect
- r_correct_pc  out  32  redirect PC
- r_err  out  1  r_valid with empty queue
- btb_wen, btb_wsel(IND_W), btb_wdat_state(2), btb_wdat_target(32), btb_phit(1)  out  BTB write port
- inv_req  in  1  start invalidate sweep
- inv_busy  out  1  sweep in progress

## Operation
Prediction (combinational):
- btb_rsel = f_pc[IND_W+1:2].
- f_pred_taken = state in {BPRED_TS, BPRED_TH}; f_pred_target = btb_rdat_target.
- During SWEEP, f_pred_taken is forced to 0.

Enqueue:
- Push when f_req && f_is_branch && !q_full.
- Entry = {pc, captured state, pred_taken, pred_target}.

Resolve (r_valid, queue non-empty):
- Pop the head entry.
- r_mispredict = (pred_taken != r_taken) || (r_taken && pred_target != r_target).
- r_correct_pc = r_taken ? r_target : pc+4.
- BTB update: btb_wen=1, wsel=head pc index, wdat_state=captured state, wdat_target = r_taken ? r_target : captured target, btb_phit=r_taken. The BTB applies the counter step.
- Mispredict squashes all younger entries: queue empty after the cycle, and a same-cycle push is discarded.

FSM:
- IDLE -> SWEEP on inv_req.
- SWEEP writes idx 0..2**IND_W-1, one per cycle, with wdat_state=BPRED_NH, phit=1, target 0. The BTB stores BPRED_NS, 0.
- After the last index, returns to IDLE. inv_req in SWEEP is ignored.
- Resolve compare and pop still operate in SWEEP, but their BTB write is dropped.

Boundaries:
- Push and pop in the same cycle: count unchanged.
- Push while full: blocked even if a pop occurs that cycle.
- r_valid on empty queue: r_err=1, no write, r_mispredict=0.
- Pointers wrap modulo QDEPTH.

## Timing
- Prediction, mispredict and correct-PC outputs: 0 cycles (combinational).
- BTB writes land on the falling CLK edge. An update is visible to reads in the following cycle. Same-index read/write in one cycle returns the old value.
- Queue state and FSM update on the rising CLK edge.
- Sweep lasts exactly 2**IND_W cycles. inv_busy rises the cycle after inv_req and falls after the last write.
- Reset: queue empty, FSM IDLE, sweep index 0.
  - Registered-derived outputs are 0: q_full, inv_busy, btb_wen, r_mispredict, r_err.
  - Reset mid-sweep or mid-queue discards all state.

## Structure
- dp_types_pkg holds bpred_state_t (BPRED_NH/NS/TS/TH), the btb_pred_entry_t queue struct, and the btb_ctrl_state_t {IDLE, SWEEP} enum.
- Sub-module pred_queue (QDEPTH-entry FIFO with push, pop and clear) is instantiated once.
- The FSM and write-port mux live in the top.

## Test plan
- Cold predict: after reset, f_pc=0x40 branch -> f_pred_taken=0; resolve r_taken=1, r_target=0x100 -> r_mispredict=1, r_correct_pc=0x100, btb write idx 0x10 state NS->TS.
- Warm predict: repeat the fetch of 0x40 -> f_pred_taken=1, target 0x100; resolve taken to 0x100 -> r_mispredict=0, entry saturates at TH.
- Queue full: push 4 branches without resolving -> q_full=1, 5th not enqueued; one pop -> q_full=0 next cycle.
- Squash: 3 entries queued, the oldest resolves mispredicted with a concurrent push -> queue empty, pushed entry dropped.
- Sweep: inv_req -> inv_busy high 256 cycles; all 256 entries read BPRED_NS/0 afterward; a resolve during the sweep produces no write.
- Reset mid-sweep at idx 100 -> inv_busy=0, q_full=0, next inv_req restarts at idx 0.
